dff_input_debounce: RTL and testbench
=====================================

Name: dff_input_debounce

Overview:
- Upstream conditioning stage for the D input of the async-reset D flip-flop stage.
- Takes a raw, asynchronous, bouncing input (switch or pad) and synchronises it into clk.
- Filters it with a stability counter and presents a clean level on d_out, which drives the flop's D.
- Also emits single-cycle rise/fall pulses for downstream edge-triggered logic.

Parameters:
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- CNT_WIDTH, 16: debounce counter width.
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronised cycles required to accept a new level; legal range 1..2^CNT_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock (single clock domain).
- reset_n  input  1  asynchronous, active-low reset.
- din_raw  input  1  raw asynchronous input.
- enable  input  1  filter enable; low freezes the filter.
- d_out  output  1  debounced level; drives the downstream flop's D.
- rise_pulse  output  1  one-cycle pulse when d_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when d_out goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n; assertion acts immediately, independent of clk.
- Reset values:
  - All synchroniser flops = 0.
  - FSM = STABLE_LO, counter = 0.
  - d_out = 0, rise_pulse = 0, fall_pulse = 0, busy = 0.
- Reset mid-operation: any qualification in progress is abandoned and all state returns to reset values at once, with no pulse emitted. Deassertion needs no special handling inside this block.
- Synchroniser: SYNC_STAGES flops in series on din_raw. Its last stage is din_s. No other logic reads din_raw.
- FSM states, 2-bit: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
  - STABLE_LO: if din_s=1, go to CHECK_HI and set cnt=0.
  - CHECK_HI, din_s=0 (bounce): return to STABLE_LO and set cnt=0.
  - CHECK_HI, din_s=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, set d_out=1, pulse rise_pulse for 1 cycle.
  - CHECK_HI, din_s=1 otherwise: cnt++.
  - STABLE_HI and CHECK_LO mirror the above with polarity inverted; the accepting transition sets d_out=0 and pulses fall_pulse.
- busy = 1 exactly when the FSM is in CHECK_HI or CHECK_LO. It is a registered decode of state.
- Latency: if din_raw is stable before edge N, d_out changes at edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1+1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges after the first sampling edge.
- Glitches: a pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes d_out.
- DEBOUNCE_CYCLES=1: the accepting transition occurs on the first CHECK cycle.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible. The compare is exact-equal at CNT_WIDTH bits.
- enable=0:
  - FSM, cnt and d_out hold their values; pulses are forced to 0.
  - The synchroniser keeps running.
  - When enable returns high, qualification resumes from the held cnt.
- Simultaneous events:
  - A bounce in the same cycle as cnt reaching the limit counts as a bounce (din_s=0 wins); no transition occurs.
  - enable falling in that same cycle blocks the transition.
- rise_pulse and fall_pulse are mutually exclusive and never high on consecutive cycles.
- All outputs are registered.

Decomposition:
- Shared package/include debounce_pkg holds:
  - state encoding localparams: ST_STABLE_LO=2'd0, ST_CHECK_HI=2'd1, ST_STABLE_HI=2'd2, ST_CHECK_LO=2'd3;
  - default parameter constants.
- One sub-module: input_sync, a parameterised SYNC_STAGES-deep synchroniser with async active-low reset to 0.
- The FSM, counter and pulse logic live in the top module.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4 and a 10 ns clk.
1. Reset: reset_n=0 at 3 ns, mid-cycle -> all outputs 0 immediately, before the next clk edge. Release at 23 ns -> outputs stay 0.
2. Clean rise: din_raw 0->1 stable from t0 -> busy high after 2 edges; d_out=1 and rise_pulse=1 on the 6th edge; rise_pulse=0 on the 7th.
3. Bounce: din_raw toggles 1,0,1,0 every 10 ns, then holds 1 -> no change to d_out during the toggling; d_out=1 exactly 6 edges after the final 0->1; exactly one rise_pulse.
4. Clean fall from d_out=1: din_raw 1->0 -> fall_pulse on the 6th edge, d_out=0; rise_pulse never asserted.
5. Enable freeze: din_raw=1, enable=0 after 2 CHECK cycles for 5 cycles, then re-enabled -> d_out rises 2 cycles after re-enable, with a single rise_pulse.
6. Reset mid-check: assert reset_n=0 while busy=1 with cnt=2 -> busy, d_out and cnt go to 0 immediately. After release with din_raw still 1 -> full 6-edge latency again.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants for the input debounce stage: FSM state encoding and
// default parameter values.
package debounce_pkg;

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_CHECK_HI  = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_CHECK_LO  = 2'd3;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_CNT_WIDTH       = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Only the last stage is visible to the rest of the design.
module input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/dff_input_debounce.sv
// Debounce front end for the D input of the async-reset flop stage.
// The raw input is synchronised, then a four-state FSM requires
// DEBOUNCE_CYCLES consecutive stable samples before accepting a new level.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_STABLE_LO | d_out = 0 accepted, waiting for din_s to go high
// ST_CHECK_HI  | din_s high, counting stable cycles before accepting 1
// ST_STABLE_HI | d_out = 1 accepted, waiting for din_s to go low
// ST_CHECK_LO  | din_s low, counting stable cycles before accepting 0
module dff_input_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_raw,
    input  logic enable,
    output logic d_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    // Exact-equal terminal count; cnt never passes it, so no wrap.
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 w_din_s;
    logic                 w_cnt_done;
    logic [1:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_d_out_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;
    logic                 w_busy_nxt;

    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_d_out;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_busy;

    input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (din_raw),
        .dout    (w_din_s)
    );

    assign w_cnt_done = (r_cnt == CNT_LIMIT);

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
            r_d_out <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d_out <= w_d_out_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and counter; a low enable freezes both. A bounce on the
    // terminal-count cycle is checked first so it wins over acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (enable) begin
            case (r_state)
                ST_STABLE_LO: begin
                    if (w_din_s) begin
                        w_state_nxt = ST_CHECK_HI;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_CHECK_HI: begin
                    if (!w_din_s) begin
                        w_state_nxt = ST_STABLE_LO;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_done) begin
                        w_state_nxt = ST_STABLE_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_din_s) begin
                        w_state_nxt = ST_CHECK_LO;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_CHECK_LO: begin
                    if (w_din_s) begin
                        w_state_nxt = ST_STABLE_HI;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_done) begin
                        w_state_nxt = ST_STABLE_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the transition being taken this cycle.
    always_comb begin
        w_d_out_nxt = r_d_out;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (r_state == ST_CHECK_HI && w_state_nxt == ST_STABLE_HI) begin
            w_d_out_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
        end else if (r_state == ST_CHECK_LO && w_state_nxt == ST_STABLE_LO) begin
            w_d_out_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
        end
        w_busy_nxt = (w_state_nxt == ST_CHECK_HI) || (w_state_nxt == ST_CHECK_LO);
    end

    assign d_out      = r_d_out;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dff_input_debounce.sv
// Directed bench for dff_input_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Edge k counts from the first clk edge that samples a new din_raw value.
module tb_dff_input_debounce;

    logic clk;
    logic reset_n;
    logic din_raw;
    logic enable;
    logic d_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int n_cmp;
    int n_err;

    dff_input_debounce #(
        .SYNC_STAGES     (2),
        .CNT_WIDTH       (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din_raw    (din_raw),
        .enable     (enable),
        .d_out      (d_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-phase reset with din_raw low, ends at posedge+1.
    task automatic do_reset();
        din_raw = 1'b0;
        enable  = 1'b1;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        din_raw = 1'b0;
        enable  = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, d_out, rise_pulse, fall_pulse} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_async: busy/d_out/rise/fall got %b want 0000",
                     {busy, d_out, rise_pulse, fall_pulse});
        end
        #19;
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({busy, d_out, rise_pulse, fall_pulse} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release: busy/d_out/rise/fall got %b want 0000",
                     {busy, d_out, rise_pulse, fall_pulse});
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] exp;
        din_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp = {(k >= 2 && k <= 5), (k >= 6), (k == 6), 1'b0};
            n_cmp++;
            if ({busy, d_out, rise_pulse, fall_pulse} !== exp) begin
                n_err++;
                $display("FAIL clean_rise edge %0d: busy/d_out/rise/fall got %b want %b",
                         k, {busy, d_out, rise_pulse, fall_pulse}, exp);
            end
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] exp;
        din_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp = {(k >= 2 && k <= 5), (k < 6), 1'b0, (k == 6)};
            n_cmp++;
            if ({busy, d_out, rise_pulse, fall_pulse} !== exp) begin
                n_err++;
                $display("FAIL clean_fall edge %0d: busy/d_out/rise/fall got %b want %b",
                         k, {busy, d_out, rise_pulse, fall_pulse}, exp);
            end
        end
    endtask

    // din_raw 1,0,1,0 on edges 0..3, then held 1 from edge 4 (final rise).
    task automatic test_bounce();
        logic [2:0] exp;
        int n_rise;
        n_rise = 0;
        for (int j = 0; j < 12; j++) begin
            din_raw = (j < 4) ? ((j % 2) == 0) : 1'b1;
            tick();
            n_rise += int'(rise_pulse);
            exp = {(j >= 10), (j == 10), 1'b0};
            n_cmp++;
            if ({d_out, rise_pulse, fall_pulse} !== exp) begin
                n_err++;
                $display("FAIL bounce edge %0d: d_out/rise/fall got %b want %b",
                         j, {d_out, rise_pulse, fall_pulse}, exp);
            end
        end
        n_cmp++;
        if (n_rise != 1) begin
            n_err++;
            $display("FAIL bounce_rise_count: got %0d want 1", n_rise);
        end
    endtask

    // Two CHECK cycles counted, enable low for edges 5..9, resumes at edge 10.
    task automatic test_enable_freeze();
        logic [3:0] exp;
        int n_rise;
        n_rise  = 0;
        din_raw = 1'b1;
        for (int k = 0; k < 13; k++) begin
            enable = !(k >= 5 && k <= 9);
            tick();
            n_rise += int'(rise_pulse);
            exp = {(k >= 2 && k <= 10), (k >= 11), (k == 11), 1'b0};
            n_cmp++;
            if ({busy, d_out, rise_pulse, fall_pulse} !== exp) begin
                n_err++;
                $display("FAIL enable_freeze edge %0d: busy/d_out/rise/fall got %b want %b",
                         k, {busy, d_out, rise_pulse, fall_pulse}, exp);
            end
        end
        n_cmp++;
        if (n_rise != 1) begin
            n_err++;
            $display("FAIL enable_freeze_rise_count: got %0d want 1", n_rise);
        end
    endtask

    // din_s drops exactly on the cycle cnt reaches its limit: no acceptance.
    task automatic test_bounce_at_limit();
        logic [3:0] exp;
        for (int k = 0; k < 9; k++) begin
            din_raw = (k <= 3);
            tick();
            exp = {(k >= 2 && k <= 5), 1'b0, 1'b0, 1'b0};
            n_cmp++;
            if ({busy, d_out, rise_pulse, fall_pulse} !== exp) begin
                n_err++;
                $display("FAIL bounce_at_limit edge %0d: busy/d_out/rise/fall got %b want %b",
                         k, {busy, d_out, rise_pulse, fall_pulse}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        logic [3:0] exp;
        din_raw = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        n_cmp++;
        if ({busy, d_out} !== 2'b10) begin
            n_err++;
            $display("FAIL mid_check_pre: busy/d_out got %b want 10", {busy, d_out});
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, d_out, rise_pulse, fall_pulse} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_check_reset: busy/d_out/rise/fall got %b want 0000",
                     {busy, d_out, rise_pulse, fall_pulse});
        end
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp = {(k >= 2 && k <= 5), (k >= 6), (k == 6), 1'b0};
            n_cmp++;
            if ({busy, d_out, rise_pulse, fall_pulse} !== exp) begin
                n_err++;
                $display("FAIL mid_check_relatency edge %0d: busy/d_out/rise/fall got %b want %b",
                         k, {busy, d_out, rise_pulse, fall_pulse}, exp);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b1;
        din_raw = 1'b0;
        enable  = 1'b1;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_bounce();
        test_clean_fall();
        test_bounce_at_limit();
        do_reset();
        test_enable_freeze();
        do_reset();
        test_reset_mid_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
